fp_accumulator: RTL and testbench

- Downstream consumer of the fp_double_multiplier triple-product stage in the MDP value-iteration datapath.
- Captures each IEEE-754 single-precision product when the multiplier pulses z_ack, and adds it into a running sum with a fixed-latency multi-cycle FP adder.
- On the term flagged last, publishes the sum with a one-cycle ack and clears the running sum for the next state's expectation.

---
 rtl/fp_accumulator.sv | 155 +++++++++++++++
 tb/tb_fp_accumulator.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fp_accumulator.sv
// FP32 running-sum accumulator fed by the triple-product multiplier's z_ack.
// Fixed 5-cycle add per term (unpack/align/add/normalize/pack); publishes and clears on the last term.
module fp_accumulator #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic [31:0]      output_z,
    output logic             z_ack,
    output logic             busy,
    output logic [CNT_W-1:0] term_count,
    output logic             overrun
);

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_PACK} state_t;

    state_t state_q, state_d;
    logic [31:0] term_q, term_d, acc_q, acc_d, out_q, out_d;
    logic last_q, last_d, zack_q, zack_d, busy_q, busy_d, ovr_q, ovr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic a_s_q, a_s_d, b_s_q, b_s_d;
    logic [7:0] a_e_q, a_e_d, b_e_q, b_e_d;
    logic [23:0] a_m_q, a_m_d, b_m_q, b_m_d;
    logic big_s_q, big_s_d, sml_s_q, sml_s_d;
    logic [7:0] big_e_q, big_e_d;
    logic [26:0] big_m_q, big_m_d, sml_m_q, sml_m_d;
    logic sum_s_q, sum_s_d;
    logic [7:0] sum_e_q, sum_e_d;
    logic [27:0] sum_m_q, sum_m_d;
    logic res_s_q, res_s_d, res_z_q, res_z_d;
    logic signed [9:0] res_e_q, res_e_d;
    logic [22:0] res_m_q, res_m_d;

    logic a_big;
    logic [7:0] diff, be, se;
    logic [23:0] bm, sm;
    logic [4:0] lz;
    logic [31:0] packed_res;

    // Index of the highest set bit, expressed as distance from bit 26; 27 when all zero.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        lzc27 = 5'd27;
        for (int i = 0; i < 27; i++)
            if (v[i]) lzc27 = 5'(26 - i);
    endfunction

    always_comb begin
        state_d = state_q;  term_d = term_q;  acc_d = acc_q;  out_d = out_q;
        last_d = last_q;    zack_d = 1'b0;    busy_d = busy_q; ovr_d = ovr_q;
        cnt_d = cnt_q;
        a_s_d = a_s_q; a_e_d = a_e_q; a_m_d = a_m_q;
        b_s_d = b_s_q; b_e_d = b_e_q; b_m_d = b_m_q;
        big_s_d = big_s_q; sml_s_d = sml_s_q; big_e_d = big_e_q;
        big_m_d = big_m_q; sml_m_d = sml_m_q;
        sum_s_d = sum_s_q; sum_e_d = sum_e_q; sum_m_d = sum_m_q;
        res_s_d = res_s_q; res_z_d = res_z_q; res_e_d = res_e_q; res_m_d = res_m_q;
        a_big = 1'b0; diff = 8'd0; be = 8'd0; se = 8'd0; bm = 24'd0; sm = 24'd0;
        lz = 5'd0; packed_res = 32'd0;

        if (in_valid && state_q != S_IDLE) ovr_d = 1'b1;

        case (state_q)
            S_IDLE: if (in_valid) begin
                term_d  = in_data;
                last_d  = in_last;
                busy_d  = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = S_UNPACK;
            end
            S_UNPACK: begin
                // Exponent 0 means zero; denormal mantissas are dropped.
                a_s_d = acc_q[31];  a_e_d = acc_q[30:23];
                a_m_d = (acc_q[30:23] == 8'd0) ? 24'd0 : {1'b1, acc_q[22:0]};
                b_s_d = term_q[31]; b_e_d = term_q[30:23];
                b_m_d = (term_q[30:23] == 8'd0) ? 24'd0 : {1'b1, term_q[22:0]};
                state_d = S_ALIGN;
            end
            S_ALIGN: begin
                a_big = (a_e_q > b_e_q) || (a_e_q == b_e_q && a_m_q >= b_m_q);
                be = a_big ? a_e_q : b_e_q;  se = a_big ? b_e_q : a_e_q;
                bm = a_big ? a_m_q : b_m_q;  sm = a_big ? b_m_q : a_m_q;
                diff    = be - se;
                big_s_d = a_big ? a_s_q : b_s_q;
                sml_s_d = a_big ? b_s_q : a_s_q;
                big_e_d = be;
                big_m_d = {bm, 3'b000};
                sml_m_d = (diff >= 8'd27) ? 27'd0 : ({sm, 3'b000} >> diff);
                state_d = S_ADD;
            end
            S_ADD: begin
                sum_s_d = big_s_q;
                sum_e_d = big_e_q;
                sum_m_d = (big_s_q == sml_s_q) ? {1'b0, big_m_q} + {1'b0, sml_m_q}
                                               : {1'b0, big_m_q} - {1'b0, sml_m_q};
                state_d = S_NORM;
            end
            S_NORM: begin
                lz      = lzc27(sum_m_q[26:0]);
                res_s_d = sum_s_q;
                res_z_d = (sum_m_q == 28'd0);
                if (sum_m_q[27]) begin
                    res_e_d = $signed({2'b00, sum_e_q}) + 10'sd1;
                    res_m_d = sum_m_q[26:4];
                end else begin
                    res_e_d = $signed({2'b00, sum_e_q}) - $signed({5'd0, lz});
                    res_m_d = 23'((sum_m_q[25:0] << lz) >> 3);
                end
                state_d = S_PACK;
            end
            S_PACK: begin
                if (res_z_q || res_e_q <= 10'sd0) packed_res = 32'd0;
                else if (res_e_q >= 10'sd255)     packed_res = {res_s_q, 8'hFF, 23'd0};
                else                              packed_res = {res_s_q, res_e_q[7:0], res_m_q};
                acc_d   = packed_res;
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (last_q) begin
                    out_d  = packed_res;
                    zack_d = 1'b1;
                    acc_d  = 32'd0;
                    cnt_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE; term_q <= '0; acc_q <= '0; out_q <= '0;
            last_q <= 1'b0; zack_q <= 1'b0; busy_q <= 1'b0; ovr_q <= 1'b0; cnt_q <= '0;
            a_s_q <= 1'b0; a_e_q <= '0; a_m_q <= '0; b_s_q <= 1'b0; b_e_q <= '0; b_m_q <= '0;
            big_s_q <= 1'b0; sml_s_q <= 1'b0; big_e_q <= '0; big_m_q <= '0; sml_m_q <= '0;
            sum_s_q <= 1'b0; sum_e_q <= '0; sum_m_q <= '0;
            res_s_q <= 1'b0; res_z_q <= 1'b0; res_e_q <= '0; res_m_q <= '0;
        end else begin
            state_q <= state_d; term_q <= term_d; acc_q <= acc_d; out_q <= out_d;
            last_q <= last_d; zack_q <= zack_d; busy_q <= busy_d; ovr_q <= ovr_d; cnt_q <= cnt_d;
            a_s_q <= a_s_d; a_e_q <= a_e_d; a_m_q <= a_m_d; b_s_q <= b_s_d; b_e_q <= b_e_d; b_m_q <= b_m_d;
            big_s_q <= big_s_d; sml_s_q <= sml_s_d; big_e_q <= big_e_d; big_m_q <= big_m_d; sml_m_q <= sml_m_d;
            sum_s_q <= sum_s_d; sum_e_q <= sum_e_d; sum_m_q <= sum_m_d;
            res_s_q <= res_s_d; res_z_q <= res_z_d; res_e_q <= res_e_d; res_m_q <= res_m_d;
        end
    end

    assign output_z   = out_q;
    assign z_ack      = zack_q;
    assign busy       = busy_q;
    assign term_count = cnt_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_fp_accumulator.sv
// Bench for fp_accumulator: directed sums, overrun/drop cases, mid-op reset, random sums vs a reference.
module tb_fp_accumulator;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic [31:0] output_z;
    logic        z_ack;
    logic        busy;
    logic [7:0]  term_count;
    logic        overrun;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    fp_accumulator #(.CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .output_z(output_z), .z_ack(z_ack), .busy(busy), .term_count(term_count), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: exact integer arithmetic on 27-bit aligned magnitudes, truncating result.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        longint ma, mb, x, y, s;
        int ea, eb, e, diff;
        logic sg, same;
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        ma = (ea == 0) ? 0 : (longint'(a[22:0]) + (longint'(1) << 23));
        mb = (eb == 0) ? 0 : (longint'(b[22:0]) + (longint'(1) << 23));
        same = (a[31] == b[31]);
        if (ea > eb || (ea == eb && ma >= mb)) begin
            e = ea; x = ma * 8; y = mb * 8; diff = ea - eb; sg = a[31];
        end else begin
            e = eb; x = mb * 8; y = ma * 8; diff = eb - ea; sg = b[31];
        end
        y = (diff >= 27) ? 0 : (y >> diff);
        s = same ? x + y : x - y;
        if (s == 0) return 32'd0;
        while (s >= (longint'(1) << 27)) begin s = s >> 1; e++; end
        while (s <  (longint'(1) << 26)) begin s = s << 1; e--; end
        if (e >= 255) return {sg, 8'hFF, 23'd0};
        if (e <= 0) return 32'd0;
        return {sg, 8'(e), 23'(s >> 3)};
    endfunction

    function automatic logic [31:0] rand_term();
        int e;
        e = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(115, 135));
        return {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
    endfunction

    task automatic send(input logic [31:0] d, input logic l);
        @(negedge clk); in_valid = 1'b1; in_data = d; in_last = l;
        @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Waits up to 20 cycles for z_ack; lat counts cycles after the returning send().
    task automatic wait_ack(output logic got, output int lat, output logic [31:0] z);
        int k;
        got = 1'b0; lat = 0; z = 32'd0; k = 0;
        while (!got && k < 20) begin
            @(negedge clk); k++;
            if (z_ack) begin got = 1'b1; lat = k; z = output_z; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; in_data = 32'd0; in_last = 1'b0;
        repeat (3) @(negedge clk);
        chk_cnt++; if (output_z !== 32'd0) $display("FAIL reset_z: got %h want 0", output_z); else pass_cnt++;
        chk_cnt++; if (z_ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", z_ack); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if (term_count !== 8'd0) $display("FAIL reset_cnt: got %0d want 0", term_count); else pass_cnt++;
        chk_cnt++; if (overrun !== 1'b0) $display("FAIL reset_ovr: got %b want 0", overrun); else pass_cnt++;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] ta [4] = '{32'h3F800000, 32'h3FC00000, 32'h3F800000, 32'h7F000000};
        logic [31:0] tb [4] = '{32'h40000000, 32'hBFC00000, 32'h30800000, 32'h7F000000};
        logic [31:0] te [4] = '{32'h40400000, 32'h00000000, 32'h3F800000, 32'h7F800000};
        logic got; int lat; logic [31:0] z;
        for (int i = 0; i < 4; i++) begin
            send(ta[i], 1'b0);
            chk_cnt++; if (busy !== 1'b1) $display("FAIL dir%0d_busy: got %b want 1", i, busy); else pass_cnt++;
            repeat (6) @(negedge clk);
            send(tb[i], 1'b1);
            chk_cnt++; if (term_count !== 8'd2) $display("FAIL dir%0d_cnt: got %0d want 2", i, term_count); else pass_cnt++;
            wait_ack(got, lat, z);
            chk_cnt++; if (!got || lat != 5) $display("FAIL dir%0d_lat: got ack=%b lat=%0d want ack=1 lat=5", i, got, lat); else pass_cnt++;
            chk_cnt++; if (z !== te[i]) $display("FAIL dir%0d_sum: got %h want %h", i, z, te[i]); else pass_cnt++;
            @(negedge clk);
            chk_cnt++; if (z_ack !== 1'b0 || output_z !== te[i])
                $display("FAIL dir%0d_hold: got ack=%b z=%h want ack=0 z=%h", i, z_ack, output_z, te[i]); else pass_cnt++;
            chk_cnt++; if (term_count !== 8'd0) $display("FAIL dir%0d_clr: got %0d want 0", i, term_count); else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic got; int lat; logic [31:0] z;
        send(32'h3F800000, 1'b0); repeat (4) @(negedge clk);
        send(32'h40000000, 1'b0); repeat (4) @(negedge clk);
        send(32'h40400000, 1'b1);
        chk_cnt++; if (term_count !== 8'd3) $display("FAIL b2b_cnt: got %0d want 3", term_count); else pass_cnt++;
        wait_ack(got, lat, z);
        chk_cnt++; if (!got || z !== 32'h40C00000) $display("FAIL b2b_sum: got ack=%b z=%h want 40c00000", got, z); else pass_cnt++;
        chk_cnt++; if (overrun !== 1'b0) $display("FAIL b2b_ovr: got %b want 0", overrun); else pass_cnt++;
    endtask

    task automatic test_overrun();
        logic got; int lat; logic [31:0] z; int acks;
        send(32'h40000000, 1'b1);
        send(32'h3F800000, 1'b1);
        chk_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_flag: got %b want 1", overrun); else pass_cnt++;
        wait_ack(got, lat, z);
        chk_cnt++; if (!got || z !== 32'h40000000) $display("FAIL ovr_first: got ack=%b z=%h want 40000000", got, z); else pass_cnt++;
        acks = 0;
        repeat (10) begin @(negedge clk); if (z_ack) acks++; end
        chk_cnt++; if (acks != 0) $display("FAIL ovr_extra_ack: got %0d want 0", acks); else pass_cnt++;
        send(32'h3FC00000, 1'b1);
        chk_cnt++; if (term_count !== 8'd1) $display("FAIL ovr_cnt: got %0d want 1", term_count); else pass_cnt++;
        wait_ack(got, lat, z);
        chk_cnt++; if (!got || z !== 32'h3FC00000) $display("FAIL ovr_single: got ack=%b z=%h want 3fc00000", got, z); else pass_cnt++;
        // A term arriving in the Pack cycle is dropped.
        @(negedge clk);
        send(32'h3F800000, 1'b0); repeat (3) @(negedge clk);
        send(32'h40000000, 1'b1);
        chk_cnt++; if (term_count !== 8'd1) $display("FAIL pack_drop_cnt: got %0d want 1", term_count); else pass_cnt++;
        acks = 0;
        repeat (8) begin @(negedge clk); if (z_ack) acks++; end
        chk_cnt++; if (acks != 0) $display("FAIL pack_drop_ack: got %0d want 0", acks); else pass_cnt++;
        send(32'h40400000, 1'b1);
        chk_cnt++; if (term_count !== 8'd2) $display("FAIL pack_drop_cnt2: got %0d want 2", term_count); else pass_cnt++;
        wait_ack(got, lat, z);
        chk_cnt++; if (!got || z !== 32'h40800000) $display("FAIL pack_drop_sum: got ack=%b z=%h want 40800000", got, z); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic got; int lat; logic [31:0] z; int acks;
        @(negedge clk);
        send(32'h3F800000, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_cnt++; if (busy !== 1'b0 || z_ack !== 1'b0) $display("FAIL rmid_busy_ack: got busy=%b ack=%b want 0 0", busy, z_ack); else pass_cnt++;
        chk_cnt++; if (term_count !== 8'd0) $display("FAIL rmid_cnt: got %0d want 0", term_count); else pass_cnt++;
        chk_cnt++; if (overrun !== 1'b0 || output_z !== 32'd0) $display("FAIL rmid_ovr_z: got ovr=%b z=%h want 0 0", overrun, output_z); else pass_cnt++;
        acks = 0;
        repeat (4) begin @(negedge clk); if (z_ack) acks++; end
        reset = 1'b1;
        repeat (6) begin @(negedge clk); if (z_ack) acks++; end
        chk_cnt++; if (acks != 0) $display("FAIL rmid_ack: got %0d want 0", acks); else pass_cnt++;
        send(32'h40000000, 1'b1);
        chk_cnt++; if (term_count !== 8'd1) $display("FAIL rmid_cnt2: got %0d want 1", term_count); else pass_cnt++;
        wait_ack(got, lat, z);
        chk_cnt++; if (!got || z !== 32'h40000000) $display("FAIL rmid_sum: got ack=%b z=%h want 40000000", got, z); else pass_cnt++;
    endtask

    task automatic test_random();
        logic got; int lat; logic [31:0] z, d, acc; int n;
        for (int s = 0; s < 30; s++) begin
            n = int'($urandom_range(1, 4));
            acc = 32'd0;
            for (int t = 0; t < n; t++) begin
                d = rand_term();
                acc = ref_add(acc, d);
                send(d, (t == n - 1));
                if (t != n - 1) repeat ($urandom_range(4, 7)) @(negedge clk);
            end
            chk_cnt++; if (term_count !== 8'(n)) $display("FAIL rnd%0d_cnt: got %0d want %0d", s, term_count, n); else pass_cnt++;
            wait_ack(got, lat, z);
            chk_cnt++; if (!got || lat != 5) $display("FAIL rnd%0d_lat: got ack=%b lat=%0d want 1 5", s, got, lat); else pass_cnt++;
            chk_cnt++; if (z !== acc) $display("FAIL rnd%0d_sum: got %h want %h", s, z, acc); else pass_cnt++;
        end
        chk_cnt++; if (overrun !== 1'b0) $display("FAIL rnd_ovr: got %b want 0", overrun); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
